lsu_v1: RTL
===========

# lsu_v1

Load/store unit between the core's execute stage and `memory_v2`. It accepts one byte-addressed RISC-V load or store per transaction and converts it into word-granular `memory_v2` accesses. Sub-word stores use a read-modify-write sequence. Load results are extracted and sign- or zero-extended, and misaligned or illegal requests return an error response without touching memory.

## Interface
Parameters:
- `addr_width`, 10: word-address width; matches `memory_v2.addr_width`.
- `data_width`, 32: data width; fixed at 32 for RV32.

Ports (clock and reset first):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit idle and able to accept.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32 funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` input `addr_width+2`: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: single-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: valid with `resp_valid`; misaligned or illegal funct3.
- `mem_addr` output `addr_width`: word address, `req_addr[addr_width+1:2]`.
- `mem_wdata` output 32: to `memory_v2.data_in`.
- `mem_rdata` input 32: from `memory_v2.data_out`; valid the cycle after `mem_re`.
- `mem_we` output 1: to `memory_v2.write_enable`.
- `mem_re` output 1: to `memory_v2.read_enable`.

## Operation
- **Acceptance:** a request is accepted on a rising edge with `req_valid && req_ready`. The unit registers `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- **Error check** (on the registered request):
  - Halfword with `addr[0]=1` is an error.
  - Word with `addr[1:0]≠0` is an error.
  - Load funct3 ∈ {3, 6, 7} is an error.
  - Store funct3 > 2 is an error.
  - Error path: ERR → RESP with `resp_err=1`. No `mem_re` or `mem_we` is ever asserted.
- **FSM states:** IDLE, RD, WAIT, WR, ERR, RESP.
  - Load: IDLE → RD → WAIT → RESP → IDLE.
  - SW: IDLE → WR → RESP → IDLE.
  - SB/SH: IDLE → RD → WAIT → WR → RESP → IDLE.
- **Per-state outputs:**
  - IDLE: `req_ready=1`.
  - RD: `mem_re=1`.
  - WAIT: capture `mem_rdata` into the merge/extract register.
  - WR: `mem_we=1`, `mem_wdata` = merged word.
  - RESP: `resp_valid=1` for exactly one cycle.
- **Lane layout:** little-endian; byte k occupies bits `[8k+7:8k]`, with `k = addr[1:0]`. Halfword at offset `addr[1]*16`.
- **Load extraction:** LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- **Store merge:** SB replaces byte k with `req_wdata[7:0]`. SH replaces the halfword with `req_wdata[15:0]`. All other bits keep the read word.
- **Response path:** no backpressure; the requester must consume the `resp_valid` pulse.
- **Outputs:** `mem_*` and `resp_*` are registered and glitch-free. `mem_addr` and `mem_wdata` hold their values outside RD/WR.

## Timing
- **Reset values:** `rst=0` forces IDLE immediately (asynchronous), abandoning any in-flight transaction.
  - 0: `mem_re`, `mem_we`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_rdata`, `resp_err`, and all captured request registers.
  - 1: `req_ready`.
- **Write safety:** a reset during WR cannot leave a partial write, because `memory_v2` samples `write_enable` on the edge.
- **Latencies** (acceptance at edge N):
  - Load: `mem_re` high in cycle N..N+1; `resp_valid` high in cycle N+2..N+3.
  - SW: `mem_we` high in N..N+1; `resp_valid` in N+1..N+2.
  - SB/SH: `mem_re` high in N..N+1; `mem_we` high in N+2..N+3; `resp_valid` high in N+3..N+4.
  - Error: `resp_valid` high in N+1..N+2.
- **Re-acceptance:** `req_ready` returns high the cycle after RESP, so the earliest next acceptance is one edge after RESP ends.
- **Exclusivity:** `mem_re` and `mem_we` are never high in the same cycle.

## Structure
- **Package `lsu_pkg`:**
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum `lsu_state_t` {IDLE, RD, WAIT, WR, ERR, RESP}.
  - Shared by the core decoder.
- **Sub-module `lsu_lane_v1`:** purely combinational.
  - Inputs: `word`, `offset[1:0]`, `funct3`, `wdata`.
  - Outputs: `load_ext[31:0]` and `store_merged[31:0]`.
  - Instantiated once in `lsu_v1`.

## Test plan
- SW to addr 0x010 with 0xDEADBEEF, then LW from 0x010 → `mem_addr=4` and `mem_we` pulse at N+1; `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- Word 0x11223344 preloaded at 0x020, then SB 0xAA to 0x022 → RD, then WR with `mem_wdata=0x11AA3344`; a following LBU from 0x022 returns 0x000000AA.
- Word 0x8000F0FF at 0x030: LB from 0x030 returns 0xFFFFFFFF; LH from 0x032 returns 0xFFFF8000; LHU from 0x032 returns 0x00008000.
- LW from 0x031 and SH to 0x033 → `resp_err=1` at N+1..N+2 and `resp_rdata=0`; `mem_re` and `mem_we` stay 0 throughout; the target memory word is unchanged.
- SB in flight with `rst` pulled low during WAIT → all outputs 0 and `req_ready=1` immediately. The word is unchanged, and a new LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check used at acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        ERR,
        RESP
    } lsu_state_t;

    // Illegal funct3 for the direction, or an access not aligned to its size.
    function automatic logic lsu_req_err(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
        logic err;
        err = 1'b0;
        if (we) begin
            if (funct3 > F3_W) err = 1'b1;
        end else begin
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) err = 1'b1;
        end
        if (funct3[1:0] == 2'd1 && offset[0]) err = 1'b1;
        if (funct3 == F3_W && offset != 2'd0) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_v1.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges sub-word store data into it.
module lsu_lane_v1
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        w_half = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_ext = {{16{w_half[15]}}, w_half};
            F3_W:    load_ext = word;
            F3_BU:   load_ext = {24'd0, w_byte};
            F3_HU:   load_ext = {16'd0, w_half};
            default: load_ext = 32'd0;
        endcase

        // Sub-word stores keep every bit of the read word outside the target lane.
        store_merged = word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd1:    store_merged[15:8]  = wdata[7:0];
                    2'd2:    store_merged[23:16] = wdata[7:0];
                    2'd3:    store_merged[31:24] = wdata[7:0];
                    default: store_merged[7:0]   = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) store_merged[31:16] = wdata[15:0];
                else           store_merged[15:0]  = wdata[15:0];
            end
            default: store_merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_v1.sv
// Load/store unit: turns one byte-addressed RV32 load/store into word-granular
// memory accesses, with read-modify-write for SB/SH and an error response path.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_re asserted for the target word
// WAIT  | read data returns; extract (load) or merge (sub-word store)
// WR    | mem_we asserted with the final word
// ERR   | rejected request, no memory access
// RESP  | one-cycle resp_valid pulse
module lsu_v1
    import lsu_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [addr_width+1:0]   req_addr,
    input  logic [data_width-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [data_width-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [addr_width-1:0]   mem_addr,
    output logic [data_width-1:0]   mem_wdata,
    input  logic [data_width-1:0]   mem_rdata,
    output logic                    mem_we,
    output logic                    mem_re
);

    lsu_state_t              r_state;
    logic                    r_req_we;
    logic [2:0]              r_funct3;
    logic [addr_width+1:0]   r_addr;
    logic [data_width-1:0]   r_wdata;
    logic                    r_req_ready;
    logic                    r_mem_re;
    logic                    r_mem_we;
    logic [data_width-1:0]   r_mem_wdata;
    logic                    r_resp_valid;
    logic [data_width-1:0]   r_resp_rdata;
    logic                    r_resp_err;

    logic                    w_req_err;
    logic                    w_req_sw;
    logic [31:0]             w_load_ext;
    logic [31:0]             w_store_merged;

    assign w_req_err = lsu_req_err(req_we, req_funct3, req_addr[1:0]);
    assign w_req_sw  = req_we && (req_funct3 == F3_W);

    // mem_rdata is valid throughout WAIT, so the lanes work on it directly and
    // the extracted/merged result is what gets registered.
    lsu_lane_v1 u_lane (
        .word         (mem_rdata),
        .offset       (r_addr[1:0]),
        .funct3       (r_funct3),
        .wdata        (r_wdata),
        .load_ext     (w_load_ext),
        .store_merged (w_store_merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_req_we     <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_we    <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state <= ERR;
                        end else if (w_req_sw) begin
                            r_state     <= WR;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state  <= RD;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_mem_re <= 1'b0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    if (r_req_we) begin
                        r_state     <= WR;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_store_merged;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_ext;
                        r_resp_err   <= 1'b0;
                    end
                end
                WR: begin
                    r_mem_we     <= 1'b0;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                ERR: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_re    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr[addr_width+1:2];
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
